// File: rtl/tl_pkg.sv
// Shared mode and field encodings for the traffic-light front panel.
package tl_pkg;

  typedef enum logic [1:0] {
    MODE_OFFLINE = 2'd0,
    MODE_ONLINE  = 2'd1,
    MODE_SET     = 2'd2
  } mode_e;

  localparam logic [1:0] FIELD_GREEN  = 2'd0;
  localparam logic [1:0] FIELD_YELLOW = 2'd1;
  localparam logic [1:0] FIELD_RED    = 2'd2;

  function automatic logic [1:0] field_next(
    input logic [1:0] f
  );
    return (f == FIELD_RED) ? FIELD_GREEN : f + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser, debouncer and press-edge detector.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int          CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             level_q;
  logic [1:0]       fill;
  logic             armed;

  // A key held through reset never arms until it has been seen released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      level_q   <= 1'b0;
      key_press <= 1'b0;
      fill      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync1     <= key_raw;
      sync2     <= sync1;
      fill      <= {fill[0], 1'b1};
      level_q   <= level;
      key_press <= level & ~level_q & armed;
      if (fill[1] && !sync2)
        armed <= 1'b1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign key_level = level;

endmodule

// File: rtl/mode_ctrl.sv
// Front-panel mode controller: OFFLINE / ONLINE / SET with field editing.
// Define SET_TIMEOUT_EN to leave SET automatically after an idle period.
module mode_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int          CNT_W           = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_online,
  input  logic       key_set,
  input  logic       key_next,
  output logic       online,
  output logic       set,
  output logic [1:0] field_sel,
  output logic       commit,
  output logic       abort
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0] press;
  logic [2:0] unused_level;
  logic       p_on;
  logic       p_st;
  logic       p_nx;

  mode_e      state_q;
  mode_e      state_d;
  logic [1:0] field_q;
  logic [1:0] field_d;
  logic       commit_d;
  logic       abort_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_online (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_online),
    .key_level(unused_level[0]),
    .key_press(press[0])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_set),
    .key_level(unused_level[1]),
    .key_press(press[1])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_next (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_next),
    .key_level(unused_level[2]),
    .key_press(press[2])
  );

  assign p_on = press[0];
  assign p_st = press[1] & ~press[0];
  assign p_nx = press[2] & ~|press[1:0];

`ifdef SET_TIMEOUT_EN
  logic [31:0] idle_q;
  logic [31:0] idle_d;
  logic        idle_hit;

  // Held at zero outside SET, so entry always starts a fresh count.
  always_comb begin
    idle_d = '0;
    if (state_q == MODE_SET && !(|press))
      idle_d = idle_q + 32'd1;
  end

  assign idle_hit = (idle_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_q <= '0;
    else
      idle_q <= idle_d;
  end
`else
  logic idle_hit;
  logic unused_to;

  assign idle_hit  = 1'b0;
  assign unused_to = ^TO_LAST;
`endif

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    commit_d = 1'b0;
    abort_d  = 1'b0;
    unique case (state_q)
      MODE_OFFLINE: begin
        if (p_on)
          state_d = MODE_ONLINE;
      end
      MODE_ONLINE: begin
        unique case (1'b1)
          p_on: state_d = MODE_OFFLINE;
          p_st: begin
            state_d = MODE_SET;
            field_d = FIELD_GREEN;
          end
          default: ;
        endcase
      end
      MODE_SET: begin
        unique case (1'b1)
          p_on: begin
            state_d = MODE_OFFLINE;
            abort_d = 1'b1;
          end
          p_st: begin
            state_d  = MODE_ONLINE;
            commit_d = 1'b1;
          end
          p_nx: field_d = field_next(field_q);
          default: begin
            if (idle_hit) begin
              state_d = MODE_ONLINE;
              abort_d = 1'b1;
            end
          end
        endcase
      end
      default: state_d = MODE_OFFLINE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_OFFLINE;
      field_q <= FIELD_GREEN;
      commit  <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      commit  <= commit_d;
      abort   <= abort_d;
    end
  end

  assign online    = (state_q != MODE_OFFLINE);
  assign set       = (state_q == MODE_SET);
  assign field_sel = field_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: vector table, corner sequences and a random run
// against an event-level model (define SET_TIMEOUT_EN to cover the timeout).
module tb_mode_ctrl;

  localparam int D  = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_online = 1'b0;
  logic       key_set = 1'b0;
  logic       key_next = 1'b0;
  logic       online;
  logic       set;
  logic [1:0] field_sel;
  logic       commit;
  logic       abort;

  mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_online(key_online),
    .key_set   (key_set),
    .key_next  (key_next),
    .online    (online),
    .set       (set),
    .field_sel (field_sel),
    .commit    (commit),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_commit = 0;
  int n_abort = 0;
  int n_both = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (commit) n_commit++;
    if (abort) n_abort++;
    if (commit && abort) n_both++;
  end

  int checks = 0;
  int errors = 0;
  int t0, c0, a0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] keys);
    rst_n = 1'b0;
    {key_next, key_set, key_online} = keys;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Press the keys in mask for hold cycles, then release and wait gap cycles.
  task automatic step(input logic [2:0] mask, input int hold, input int gap);
    @(posedge clk);
    #1;
    t0 = cyc;
    c0 = n_commit;
    a0 = n_abort;
    {key_next, key_set, key_online} = mask;
    repeat (hold) @(posedge clk);
    #1 {key_next, key_set, key_online} = 3'b000;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Event-level model: mode 0/1/2, field counts modulo 3.
  int m_mode, m_fld, m_tlast, m_cm, m_ab;

  task automatic m_timeout(input int upto);
`ifdef SET_TIMEOUT_EN
    if (m_mode == 2 && m_tlast + TO <= upto) begin
      m_mode = 1;
      m_ab++;
    end
`else
    if (upto < 0) m_mode = m_mode;
`endif
  endtask

  task automatic m_step(input logic [2:0] mask, input int hold,
                        input int tstart, input int tend);
    int tev;
    tev = tstart + 2 + D + 1 + 1;
    m_cm = 0;
    m_ab = 0;
    if (hold >= D && mask != 3'b000) begin
      m_timeout(tev - 1);
      case (m_mode)
        0: if (mask[0]) m_mode = 1;
        1: begin
          if (mask[0]) m_mode = 0;
          else if (mask[1]) begin
            m_mode = 2;
            m_fld = 0;
            m_tlast = tev;
          end
        end
        default: begin
          if (mask[0]) begin
            m_mode = 0;
            m_ab++;
          end else if (mask[1]) begin
            m_mode = 1;
            m_cm++;
          end else begin
            m_fld = (m_fld + 1) % 3;
            m_tlast = tev;
          end
        end
      endcase
    end
    m_timeout(tend);
  endtask

  typedef struct {
    logic [2:0] keys;
    int         hold;
    logic       exp_on;
    logic       exp_set;
    logic [1:0] exp_fld;
    int         exp_cm;
    int         exp_ab;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lat;
    int tev;
    logic [2:0] mask;
    int hold, gap;

    tbl[0]  = '{3'b001, 6, 1'b1, 1'b0, 2'd0, 0, 0};
    tbl[1]  = '{3'b010, 6, 1'b1, 1'b1, 2'd0, 0, 0};
    tbl[2]  = '{3'b100, 6, 1'b1, 1'b1, 2'd1, 0, 0};
    tbl[3]  = '{3'b100, 6, 1'b1, 1'b1, 2'd2, 0, 0};
    tbl[4]  = '{3'b100, 6, 1'b1, 1'b1, 2'd0, 0, 0};
    tbl[5]  = '{3'b100, 6, 1'b1, 1'b1, 2'd1, 0, 0};
    tbl[6]  = '{3'b010, 6, 1'b1, 1'b0, 2'd1, 1, 0};
    tbl[7]  = '{3'b100, 6, 1'b1, 1'b0, 2'd1, 0, 0};
    tbl[8]  = '{3'b110, 6, 1'b1, 1'b1, 2'd0, 0, 0};
    tbl[9]  = '{3'b011, 6, 1'b0, 1'b0, 2'd0, 0, 1};
    tbl[10] = '{3'b010, 6, 1'b0, 1'b0, 2'd0, 0, 0};
    tbl[11] = '{3'b001, 3, 1'b0, 1'b0, 2'd0, 0, 0};

    // Keys held through reset must not act.
    do_reset(3'b111);
    c0 = n_commit;
    a0 = n_abort;
    repeat (20) @(posedge clk);
    #1;
    chk("held_rst_online", online, 0);
    chk("held_rst_set", set, 0);
    chk("held_rst_field", field_sel, 0);
    chk("held_rst_pulses", n_commit - c0 + n_abort - a0, 0);
    {key_next, key_set, key_online} = 3'b000;
    repeat (12) @(posedge clk);
    #1;
    chk("release_online", online, 0);

    // Short glitch ignored; long press measured from raw rise.
    step(3'b001, 3, 12);
    chk("glitch_online", online, 0);
    @(posedge clk);
    #1 key_online = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) key_online = 1'b0;
      if (online && lat < 0) lat = k;
    end
    chk("press_latency", lat, 8);
    step(3'b001, 6, 10);
    chk("back_offline", online, 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].keys, tbl[i].hold, 10);
      chk($sformatf("vec%0d_online", i), online, tbl[i].exp_on);
      chk($sformatf("vec%0d_set", i), set, tbl[i].exp_set);
      chk($sformatf("vec%0d_field", i), field_sel, tbl[i].exp_fld);
      chk($sformatf("vec%0d_commit", i), n_commit - c0, tbl[i].exp_cm);
      chk($sformatf("vec%0d_abort", i), n_abort - a0, tbl[i].exp_ab);
    end

    // Asynchronous reset while in SET.
    step(3'b001, 6, 10);
    step(3'b010, 6, 10);
    chk("pre_arst_set", set, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_online", online, 0);
    chk("arst_set", set, 0);
    chk("arst_pulses", {30'd0, commit, abort}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle behaviour in SET.
    repeat (4) @(posedge clk);
    step(3'b001, 6, 10);
    step(3'b010, 6, 10);
    tev = t0 + 8;
    while (cyc < tev + TO - 1) begin
      @(posedge clk);
      #1;
    end
    chk("idle_still_set", set, 1);
    a0 = n_abort;
`ifdef SET_TIMEOUT_EN
    @(posedge clk);
    #1;
    chk("timeout_set", set, 0);
    chk("timeout_online", online, 1);
    @(posedge clk);
    #1;
    chk("timeout_abort", n_abort - a0, 1);
`else
    repeat (100) @(posedge clk);
    #1;
    chk("no_timeout_set", set, 1);
    chk("no_timeout_abort", n_abort - a0, 0);
`endif

    // Random key traffic against the model.
    do_reset(3'b000);
    m_mode = 0;
    m_fld = 0;
    m_tlast = 0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      mask = 3'($urandom_range(1, 7));
      hold = $urandom_range(2, 7);
      gap = ($urandom_range(0, 3) == 0) ? 25 : 10;
      step(mask, hold, gap);
      m_step(mask, hold, t0, cyc);
      chk($sformatf("rnd%0d_online", i), online, (m_mode != 0));
      chk($sformatf("rnd%0d_set", i), set, (m_mode == 2));
      chk($sformatf("rnd%0d_field", i), field_sel, m_fld);
      chk($sformatf("rnd%0d_commit", i), n_commit - c0, m_cm);
      chk($sformatf("rnd%0d_abort", i), n_abort - a0, m_ab);
    end
    chk("pulse_exclusive", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
